// File: rtl/udp_rx_pkg.sv
// udp_rx_pkg: shared types and constants for the UDP receive-payload reader.
// FSM state encoding, UDP header length, skid buffer depth and the skid beat layout.
package udp_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_READ     = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_DONE     = 3'd4,
      ST_WAIT_CLR = 3'd5
   } rx_state_e;

   localparam int UDP_HDR_LEN     = 8;
   localparam int SKID_BASE_DEPTH = 2;

   typedef struct packed {
      logic       sof;
      logic       eof;
      logic [7:0] data;
   } rx_beat_t;

   // Two beats of slack plus one entry per cycle of RAM read latency.
   function automatic int skid_depth(input int rd_lat);
      return SKID_BASE_DEPTH + rd_lat;
   endfunction

endpackage

// File: rtl/udp_rx_reader_if.sv
// udp_rx_reader_if: payload byte stream from udp_rx_reader to its downstream consumer.
interface udp_rx_reader_if;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_sof;
   logic        m_eof;
   logic [15:0] m_len;

   modport master (output m_data, m_valid, m_sof, m_eof, m_len, input m_ready);
   modport slave  (input m_data, m_valid, m_sof, m_eof, m_len, output m_ready);
endinterface

// File: rtl/udp_rx_skid.sv
// udp_rx_skid: small circular byte FIFO absorbing receive-RAM read latency,
// with valid/ready on both sides and a synchronous flush used on MAC abort.
module udp_rx_skid
   import udp_rx_pkg::*;
#(
   parameter int DEPTH = skid_depth(1),
   parameter int W     = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic [W-1:0]                 in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [W-1:0]                 out_data,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] cnt_r;
   logic          push_s;
   logic          pop_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PW'(1'b1);
      end
   endfunction

   assign in_ready  = (cnt_r < CW'(DEPTH));
   assign out_valid = (cnt_r != '0);
   assign out_data  = mem_r[rd_ptr_r];
   assign count     = cnt_r;
   assign push_s    = in_valid & in_ready;
   assign pop_s     = out_valid & out_ready;

   // Storage, pointers and occupancy; flush discards everything buffered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   cnt_r <= cnt_r + CW'(1'b1);
            2'b01:   cnt_r <= cnt_r - CW'(1'b1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

endmodule

// File: rtl/udp_rx_reader.sv
// udp_rx_reader: reads a received UDP payload out of the MAC receive RAM and streams it downstream.
// Optional statistics counters are enabled with the UDP_RX_STATS_EN macro.
module udp_rx_reader
   import udp_rx_pkg::*;
#(
   parameter int ADDR_W  = 11,
   parameter int HDR_LEN = UDP_HDR_LEN,
   parameter int RD_LAT  = 1
) (
   input  logic              gmii_tx_clk,
   input  logic              rst_n,
   input  logic              fs_udp_rx,
   output logic              fd_udp_rx,
   input  logic [15:0]       udp_rx_len,
   output logic [ADDR_W-1:0] udp_rx_addr,
   input  logic [7:0]        udp_rxd,
   udp_rx_reader_if.master   m,
   output logic              busy
`ifdef UDP_RX_STATS_EN
   ,
   output logic [31:0]       pkt_cnt,
   output logic [15:0]       trunc_cnt,
   output logic [31:0]       byte_cnt
`endif
);

   localparam int          DEPTH = skid_depth(RD_LAT);
   localparam int          CW    = $clog2(DEPTH + 1);
   localparam logic [15:0] MAX_N = 16'(2 ** ADDR_W);
   localparam logic [15:0] HDR   = 16'(HDR_LEN);

   rx_state_e         state_r, state_s;
   logic [15:0]       len_r, mlen_r, issue_cnt_r, payload_s;
   logic [ADDR_W-1:0] addr_r;
   logic [RD_LAT-1:0] pipe_v_r, pipe_sof_r, pipe_eof_r;
   logic              fd_r, busy_r;
   logic              issue_s, abort_s, issue_ok_s, last_issue_s, accept_s;
   logic [CW:0]       inflight_s, occ_s;
   logic [CW-1:0]     skid_count_s;
   logic              skid_in_ready_s, skid_valid_s;
   rx_beat_t          push_beat_s, pop_beat_s;

   assign payload_s    = len_r - HDR;
   assign last_issue_s = (issue_cnt_r == (mlen_r - 16'd1));
   assign issue_ok_s   = (occ_s < (CW + 1)'(DEPTH));
   assign accept_s     = skid_valid_s & m.m_ready;
   assign push_beat_s  = {pipe_sof_r[RD_LAT-1], pipe_eof_r[RD_LAT-1], udp_rxd};

   // Reads in flight plus bytes already buffered bound how far ahead addressing may run.
   always_comb begin
      inflight_s = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight_s = inflight_s + {{CW{1'b0}}, pipe_v_r[i]};
      end
      occ_s = inflight_s + {1'b0, skid_count_s};
   end

   // Next-state logic, address issue and abort detection.
   always_comb begin
      state_s = state_r;
      issue_s = 1'b0;
      abort_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fs_udp_rx) state_s = ST_LOAD;
            else           state_s = ST_IDLE;
         end
         ST_LOAD: begin
            if (len_r <= HDR) state_s = ST_DONE;
            else              state_s = ST_READ;
         end
         ST_READ: begin
            if (!fs_udp_rx) begin
               abort_s = 1'b1;
               state_s = ST_IDLE;
            end else if (issue_ok_s) begin
               issue_s = 1'b1;
               if (last_issue_s) state_s = ST_DRAIN;
               else              state_s = ST_READ;
            end else begin
               state_s = ST_READ;
            end
         end
         ST_DRAIN: begin
            if (!fs_udp_rx) begin
               abort_s = 1'b1;
               state_s = ST_IDLE;
            end else if (accept_s && pop_beat_s.eof) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_DONE: state_s = ST_WAIT_CLR;
         ST_WAIT_CLR: begin
            if (!fs_udp_rx) state_s = ST_IDLE;
            else            state_s = ST_WAIT_CLR;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_s;
   end

   // Length latch, clipped payload length, byte/address counters and status outputs.
   always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         fd_r        <= 1'b0;
         busy_r      <= 1'b0;
         len_r       <= 16'd0;
         mlen_r      <= 16'd0;
         issue_cnt_r <= 16'd0;
         addr_r      <= '0;
      end else begin
         fd_r   <= (state_s == ST_DONE);
         busy_r <= (state_s != ST_IDLE);
         if (state_r == ST_IDLE && fs_udp_rx) begin
            len_r <= udp_rx_len;
         end
         if (state_r == ST_LOAD) begin
            issue_cnt_r <= 16'd0;
            addr_r      <= '0;
            if (len_r <= HDR)            mlen_r <= 16'd0;
            else if (payload_s > MAX_N)  mlen_r <= MAX_N;
            else                         mlen_r <= payload_s;
         end else if (issue_s) begin
            issue_cnt_r <= issue_cnt_r + 16'd1;
            // Hold on the last address so a full 2**ADDR_W clip never wraps to 0.
            if (!last_issue_s) addr_r <= addr_r + ADDR_W'(1'b1);
         end
      end
   end

   // Read-latency pipeline tagging each issued address with its framing bits.
   always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_v_r   <= '0;
         pipe_sof_r <= '0;
         pipe_eof_r <= '0;
      end else if (abort_s) begin
         pipe_v_r   <= '0;
         pipe_sof_r <= '0;
         pipe_eof_r <= '0;
      end else begin
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v_r[i]   <= pipe_v_r[i-1];
            pipe_sof_r[i] <= pipe_sof_r[i-1];
            pipe_eof_r[i] <= pipe_eof_r[i-1];
         end
         pipe_v_r[0]   <= issue_s;
         pipe_sof_r[0] <= issue_s & (issue_cnt_r == 16'd0);
         pipe_eof_r[0] <= issue_s & last_issue_s;
      end
   end

   udp_rx_skid #(
      .DEPTH (DEPTH),
      .W     ($bits(rx_beat_t))
   ) u_skid (
      .clk       (gmii_tx_clk),
      .rst_n     (rst_n),
      .flush     (abort_s),
      .in_valid  (pipe_v_r[RD_LAT-1] & skid_in_ready_s),
      .in_data   (push_beat_s),
      .in_ready  (skid_in_ready_s),
      .out_valid (skid_valid_s),
      .out_data  (pop_beat_s),
      .out_ready (m.m_ready),
      .count     (skid_count_s)
   );

   assign m.m_valid   = skid_valid_s;
   assign m.m_data    = pop_beat_s.data;
   assign m.m_sof     = pop_beat_s.sof;
   assign m.m_eof     = pop_beat_s.eof;
   assign m.m_len     = mlen_r;
   assign fd_udp_rx   = fd_r;
   assign busy        = busy_r;
   assign udp_rx_addr = addr_r;

`ifdef UDP_RX_STATS_EN
   // Completed packets, truncations (clip or abort) and accepted bytes; all wrap.
   always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt   <= 32'd0;
         trunc_cnt <= 16'd0;
         byte_cnt  <= 32'd0;
      end else begin
         if (state_r == ST_DONE) pkt_cnt <= pkt_cnt + 32'd1;
         if (abort_s || (state_r == ST_LOAD && len_r > HDR && payload_s > MAX_N)) begin
            trunc_cnt <= trunc_cnt + 16'd1;
         end
         if (accept_s) byte_cnt <= byte_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_udp_rx_reader.sv
// tb_udp_rx_reader: drives two readers (RAM latency 1 and 2) with shared stimulus and checks
// each accepted byte stream against a payload model built from the packet length rules.
module tb_udp_rx_reader;

   logic        clk = 1'b0;
   logic        rst_n, fs, rdy, rdy_rand;
   logic [15:0] len;
   logic [7:0]  ram [0:2047];
   logic [10:0] addr0, addr1;
   logic [7:0]  rxd0, rxd1, rxd1_q;
   logic        fd0, fd1, busy0, busy1;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   logic [9:0]  got0[$], got1[$];
   int          ac0[$], ac1[$];
   int          fdn0, fdn1, fdc0, fdc1;

   udp_rx_reader_if bus0();
   udp_rx_reader_if bus1();
   assign bus0.m_ready = rdy;
   assign bus1.m_ready = rdy;

`ifdef UDP_RX_STATS_EN
   logic [31:0] pkt0, pkt1, byt0, byt1;
   logic [15:0] trunc0, trunc1;
`endif

   udp_rx_reader #(.ADDR_W(11), .HDR_LEN(8), .RD_LAT(1)) dut0 (
      .gmii_tx_clk(clk), .rst_n(rst_n), .fs_udp_rx(fs), .fd_udp_rx(fd0),
      .udp_rx_len(len), .udp_rx_addr(addr0), .udp_rxd(rxd0), .m(bus0), .busy(busy0)
`ifdef UDP_RX_STATS_EN
      , .pkt_cnt(pkt0), .trunc_cnt(trunc0), .byte_cnt(byt0)
`endif
   );

   udp_rx_reader #(.ADDR_W(11), .HDR_LEN(8), .RD_LAT(2)) dut1 (
      .gmii_tx_clk(clk), .rst_n(rst_n), .fs_udp_rx(fs), .fd_udp_rx(fd1),
      .udp_rx_len(len), .udp_rx_addr(addr1), .udp_rxd(rxd1), .m(bus1), .busy(busy1)
`ifdef UDP_RX_STATS_EN
      , .pkt_cnt(pkt1), .trunc_cnt(trunc1), .byte_cnt(byt1)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      rxd0   <= ram[addr0];
      rxd1_q <= ram[addr1];
      rxd1   <= rxd1_q;
   end

   always @(posedge clk) begin
      #1;
      if (rdy_rand) rdy = ($urandom_range(0, 1) == 1);
   end

   // Record every handshake and every fd pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus0.m_valid && bus0.m_ready) begin
            got0.push_back({bus0.m_sof, bus0.m_eof, bus0.m_data});
            ac0.push_back(cyc);
         end
         if (bus1.m_valid && bus1.m_ready) begin
            got1.push_back({bus1.m_sof, bus1.m_eof, bus1.m_data});
            ac1.push_back(cyc);
         end
         if (fd0) begin fdn0 = fdn0 + 1; fdc0 = cyc; end
         if (fd1) begin fdn1 = fdn1 + 1; fdc1 = cyc; end
      end
   end

   function automatic int exp_n(input logic [15:0] l);
      if (l <= 16'd8) return 0;
      else if (l - 16'd8 > 16'd2048) return 2048;
      else return int'(l - 16'd8);
   endfunction

   function automatic logic [9:0] exp_beat(input int i, input int n);
      return {(i == 0), (i == n - 1), ram[i]};
   endfunction

   function automatic int got_size(input int d);
      return (d == 0) ? got0.size() : got1.size();
   endfunction

   // -1 when the stream equals the model of n bytes, else index of first disagreement.
   function automatic int first_diff(input int d, input int n);
      int sz;
      logic [9:0] g;
      sz = got_size(d);
      for (int i = 0; i < sz && i < n; i++) begin
         g = (d == 0) ? got0[i] : got1[i];
         if (g !== exp_beat(i, n)) return i;
      end
      if (sz != n) return (sz < n) ? sz : n;
      return -1;
   endfunction

   function automatic logic [39:0] outs(input int d);
      if (d == 0)
         return {fd0, addr0, bus0.m_valid, bus0.m_sof, bus0.m_eof, bus0.m_data, bus0.m_len, busy0};
      else
         return {fd1, addr1, bus1.m_valid, bus1.m_sof, bus1.m_eof, bus1.m_data, bus1.m_len, busy1};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got0.delete(); got1.delete(); ac0.delete(); ac1.delete();
      fdn0 = 0; fdn1 = 0; fdc0 = -1; fdc1 = -1;
   endtask

   task automatic start_pkt(input logic [15:0] l, output int c);
      step();
      len = l;
      fs  = 1'b1;
      c   = cyc;
   endtask

   // Hold fs until both readers pulse fd, then release it like the MAC does.
   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (fdn0 > 0 && fdn1 > 0) begin ok = 1'b1; break; end
      end
      step();
      fs = 1'b0;
      repeat (3) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; fs = 1'b0; len = 16'd0; rdy = 1'b0; rdy_rand = 1'b0;
      clear_mon();
      repeat (3) step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (outs(d) !== 40'd0) begin
            errors++; $display("FAIL reset_outputs dut%0d got %h want 0", d, outs(d));
         end
      end
      rst_n = 1'b1;
      repeat (2) step();
   endtask

   task automatic test_basic();
      int c; bit ok; int fd; int first; int last;
      rdy = 1'b1;
      clear_mon();
      start_pkt(16'd18, c);
      wait_done(200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout got no fd want fd"); end
      for (int d = 0; d < 2; d++) begin
         fd = first_diff(d, 10);
         checks++;
         if (fd != -1) begin
            errors++; $display("FAIL basic_stream dut%0d first bad index %0d size %0d want 10", d, fd, got_size(d));
         end
         checks++;
         if ((d == 0 ? bus0.m_len : bus1.m_len) !== 16'd10) begin
            errors++; $display("FAIL basic_m_len dut%0d got %0d want 10", d, (d == 0 ? bus0.m_len : bus1.m_len));
         end
         checks++;
         if ((d == 0 ? fdn0 : fdn1) != 1) begin
            errors++; $display("FAIL basic_fd_count dut%0d got %0d want 1", d, (d == 0 ? fdn0 : fdn1));
         end
         first = -1; last = -1;
         if (d == 0 && ac0.size() > 0) begin first = ac0[0]; last = ac0[ac0.size()-1]; end
         if (d == 1 && ac1.size() > 0) begin first = ac1[0]; last = ac1[ac1.size()-1]; end
         checks++;
         if (first != c + 3 + (d + 1)) begin
            errors++; $display("FAIL basic_latency dut%0d first byte cycle %0d want %0d", d, first, c + 4 + d);
         end
         checks++;
         if (last - first != 9) begin
            errors++; $display("FAIL basic_back_to_back dut%0d span %0d want 9", d, last - first);
         end
      end
   endtask

   task automatic test_zero_payload();
      int c; bit ok;
      logic [15:0] lens [2];
      lens[0] = 16'd8; lens[1] = 16'd5;
      rdy = 1'b1;
      for (int k = 0; k < 2; k++) begin
         clear_mon();
         start_pkt(lens[k], c);
         wait_done(50, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL zero_timeout len %0d got no fd want fd", lens[k]); end
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (got_size(d) != 0) begin
               errors++; $display("FAIL zero_no_bytes dut%0d len %0d got %0d bytes want 0", d, lens[k], got_size(d));
            end
            checks++;
            if ((d == 0 ? fdn0 : fdn1) != 1) begin
               errors++; $display("FAIL zero_fd_count dut%0d got %0d want 1", d, (d == 0 ? fdn0 : fdn1));
            end
            checks++;
            if ((d == 0 ? fdc0 : fdc1) != c + 2) begin
               errors++; $display("FAIL zero_fd_cycle dut%0d got %0d want %0d", d, (d == 0 ? fdc0 : fdc1), c + 2);
            end
         end
      end
   endtask

   task automatic test_random_backpressure();
      int c; bit ok; int n; int fd;
      logic [15:0] l;
      rdy_rand = 1'b1;
      for (int k = 0; k < 5; k++) begin
         l = (k == 0) ? 16'd72 : 16'($urandom_range(9, 300));
         n = exp_n(l);
         clear_mon();
         start_pkt(l, c);
         wait_done(3000, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL random_timeout len %0d got no fd want fd", l); end
         for (int d = 0; d < 2; d++) begin
            fd = first_diff(d, n);
            checks++;
            if (fd != -1) begin
               errors++; $display("FAIL random_stream dut%0d len %0d first bad index %0d size %0d want %0d", d, l, fd, got_size(d), n);
            end
         end
      end
      rdy_rand = 1'b0;
      step();
      rdy = 1'b1;
   endtask

   task automatic test_single_byte();
      int c; bit ok; int fd;
      rdy = 1'b1;
      clear_mon();
      start_pkt(16'd9, c);
      wait_done(100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_timeout got no fd want fd"); end
      for (int d = 0; d < 2; d++) begin
         fd = first_diff(d, 1);
         checks++;
         if (fd != -1) begin
            errors++; $display("FAIL single_sof_eof dut%0d first bad index %0d size %0d want 1", d, fd, got_size(d));
         end
      end
   endtask

   task automatic test_clip();
      int c; bit ok; int fd;
      rdy = 1'b1;
      clear_mon();
      start_pkt(16'hFFFF, c);
      wait_done(5000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL clip_timeout got no fd want fd"); end
      for (int d = 0; d < 2; d++) begin
         fd = first_diff(d, 2048);
         checks++;
         if (fd != -1) begin
            errors++; $display("FAIL clip_stream dut%0d first bad index %0d size %0d want 2048", d, fd, got_size(d));
         end
         checks++;
         if ((d == 0 ? bus0.m_len : bus1.m_len) !== 16'd2048) begin
            errors++; $display("FAIL clip_m_len dut%0d got %0d want 2048", d, (d == 0 ? bus0.m_len : bus1.m_len));
         end
      end
`ifdef UDP_RX_STATS_EN
      checks++;
      if (trunc0 !== 16'd1 || trunc1 !== 16'd1) begin
         errors++; $display("FAIL clip_trunc_cnt got %0d/%0d want 1", trunc0, trunc1);
      end
`endif
   endtask

   task automatic test_abort();
      int c; bit ok; int fd;
      logic [9:0] g;
      rdy = 1'b0;
      clear_mon();
      start_pkt(16'd20, c);
      repeat (10) step();
      rdy = 1'b1;
      repeat (3) step();
      rdy = 1'b0;
      fs  = 1'b0;
      repeat (2) step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ((d == 0 ? busy0 : busy1) !== 1'b0) begin
            errors++; $display("FAIL abort_busy dut%0d got %b want 0", d, (d == 0 ? busy0 : busy1));
         end
         checks++;
         if ((d == 0 ? bus0.m_valid : bus1.m_valid) !== 1'b0) begin
            errors++; $display("FAIL abort_flush dut%0d m_valid got 1 want 0", d);
         end
      end
      repeat (5) step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (got_size(d) != 3) begin
            errors++; $display("FAIL abort_count dut%0d got %0d bytes want 3", d, got_size(d));
         end
         for (int i = 0; i < 3 && i < got_size(d); i++) begin
            g = (d == 0) ? got0[i] : got1[i];
            checks++;
            if (g !== exp_beat(i, 12)) begin
               errors++; $display("FAIL abort_prefix dut%0d byte %0d got %h want %h", d, i, g, exp_beat(i, 12));
            end
         end
         checks++;
         if ((d == 0 ? fdn0 : fdn1) != 0) begin
            errors++; $display("FAIL abort_no_fd dut%0d got %0d pulses want 0", d, (d == 0 ? fdn0 : fdn1));
         end
      end
      rdy = 1'b1;
      clear_mon();
      start_pkt(16'd12, c);
      wait_done(100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL abort_restart_timeout got no fd want fd"); end
      for (int d = 0; d < 2; d++) begin
         fd = first_diff(d, 4);
         checks++;
         if (fd != -1) begin
            errors++; $display("FAIL abort_restart_stream dut%0d first bad index %0d size %0d want 4", d, fd, got_size(d));
         end
      end
`ifdef UDP_RX_STATS_EN
      checks++;
      if (trunc0 !== 16'd2 || trunc1 !== 16'd2) begin
         errors++; $display("FAIL abort_trunc_cnt got %0d/%0d want 2", trunc0, trunc1);
      end
`endif
   endtask

   task automatic test_async_reset();
      int c;
      rdy = 1'b0;
      clear_mon();
      start_pkt(16'd30, c);
      repeat (6) step();
      checks++;
      if (bus0.m_valid !== 1'b1 || bus1.m_valid !== 1'b1) begin
         errors++; $display("FAIL async_pre_valid got %b%b want 11", bus0.m_valid, bus1.m_valid);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (outs(d) !== 40'd0) begin
            errors++; $display("FAIL async_reset dut%0d got %h want 0", d, outs(d));
         end
      end
      fs = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (2) step();
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom_range(0, 255));
      test_reset();
      test_basic();
      test_zero_payload();
      test_random_backpressure();
      test_single_byte();
      test_clip();
      test_abort();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
